// File: rtl/ldo_ctrl_v2.sv
// Digital LDO controller: synchronised comparator decision drives a thermometer PT array,
// with fixed or adaptive (coarse/fine) stepping, limit-cycle lock detect and test modes.
module ldo_ctrl_v2 #(
  parameter int unsigned ARRSZ   = 9,
  parameter int unsigned TRIMW   = 10,
  parameter int unsigned MAXSTEP = 4,
  parameter int unsigned RUNLEN  = 3,
  parameter int unsigned LOCKN   = 4,
  parameter int unsigned CLKDIV  = 1,
  localparam int unsigned CW     = $clog2(ARRSZ + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode_sel,
  input  logic [TRIMW-1:0] trim,
  input  logic             cmp_in,
  input  logic             std_ctrl_in,
  input  logic [CW-1:0]    std_pt_in_cnt,
  output logic             cmp_out,
  output logic [CW-1:0]    ctrl_out,
  output logic [ARRSZ-1:0] pt_en,
  output logic [TRIMW-1:0] trim_out,
  output logic             lock
);

  localparam int unsigned RW = $clog2(RUNLEN + 1);
  localparam int unsigned LW = $clog2(LOCKN + 1);
  localparam int unsigned TW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [1:0] {
    M_PT    = 2'b00,
    M_CTRL  = 2'b01,
    M_FIXED = 2'b10,
    M_ADAPT = 2'b11
  } mode_e;

  mode_e            mode_q, mode_d, mode_in;
  logic             sync_q, cmp_q, sync_in;
  logic [CW-1:0]    ctrl_q, ctrl_d, load_cnt;
  logic [TRIMW-1:0] trim_q, trim_d;
  logic             lock_q, lock_d;
  logic [CW-1:0]    step_q, step_d;
  logic [RW-1:0]    run_q, run_d, run_inc;
  logic [LW-1:0]    rev_q, rev_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             lastdec_q, lastdec_d, lastv_q, lastv_d;
  logic [CW:0]      s, up, dbl;
  logic             reversal;

  assign mode_in  = mode_e'(mode_sel);
  assign sync_in  = (mode_in == M_CTRL) ? std_ctrl_in : cmp_in;
  assign load_cnt = (std_pt_in_cnt > CW'(ARRSZ)) ? CW'(ARRSZ) : std_pt_in_cnt;
  assign s        = (mode_q == M_ADAPT) ? {1'b0, step_q} : (CW+1)'(1);
  assign up       = {1'b0, ctrl_q} + s;
  assign dbl      = {1'b0, step_q} << 1;
  assign run_inc  = run_q + RW'(1);
  assign reversal = lastv_q && (cmp_q != lastdec_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= M_PT;
      sync_q    <= 1'b0;
      cmp_q     <= 1'b0;
      ctrl_q    <= '0;
      trim_q    <= '0;
      lock_q    <= 1'b0;
      step_q    <= CW'(MAXSTEP);
      run_q     <= '0;
      rev_q     <= '0;
      tick_q    <= '0;
      lastdec_q <= 1'b0;
      lastv_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sync_q    <= sync_in;
      cmp_q     <= sync_q;
      ctrl_q    <= ctrl_d;
      trim_q    <= trim_d;
      lock_q    <= lock_d;
      step_q    <= step_d;
      run_q     <= run_d;
      rev_q     <= rev_d;
      tick_q    <= tick_d;
      lastdec_q <= lastdec_d;
      lastv_q   <= lastv_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    ctrl_d    = ctrl_q;
    trim_d    = trim_q;
    lock_d    = lock_q;
    step_d    = step_q;
    run_d     = run_q;
    rev_d     = rev_q;
    tick_d    = tick_q;
    lastdec_d = lastdec_q;
    lastv_d   = lastv_q;
    if (mode_in != mode_q) begin
      // Mode change: restart adaptation, never update the count in the same cycle.
      mode_d  = mode_in;
      step_d  = CW'(MAXSTEP);
      run_d   = '0;
      rev_d   = '0;
      tick_d  = '0;
      lastv_d = 1'b0;
      lock_d  = 1'b0;
      if (mode_in == M_PT) ctrl_d = load_cnt;
      if (mode_in == M_PT || mode_in == M_CTRL) trim_d = trim;
    end else if (mode_q == M_PT) begin
      ctrl_d = load_cnt;
      trim_d = trim;
    end else begin
      if (mode_q == M_CTRL) trim_d = trim;
      if (tick_q == TW'(CLKDIV - 1)) begin
        tick_d = '0;
        if (cmp_q)
          ctrl_d = (up > (CW+1)'(ARRSZ)) ? CW'(ARRSZ) : up[CW-1:0];
        else
          ctrl_d = ({1'b0, ctrl_q} < s) ? '0 : ctrl_q - s[CW-1:0];
        if (mode_q == M_ADAPT) begin
          if (reversal) begin
            step_d = (step_q > CW'(1)) ? (step_q >> 1) : CW'(1);
            run_d  = RW'(1);
          end else if (run_inc == RW'(RUNLEN)) begin
            step_d = (dbl > (CW+1)'(MAXSTEP)) ? CW'(MAXSTEP) : dbl[CW-1:0];
            run_d  = '0;
          end else begin
            run_d = run_inc;
          end
        end
        // Reversals at a coarse step neither count towards nor break lock.
        if (!reversal)
          rev_d = '0;
        else if (s == (CW+1)'(1) && rev_q != LW'(LOCKN))
          rev_d = rev_q + LW'(1);
        lock_d    = (rev_d == LW'(LOCKN));
        lastdec_d = cmp_q;
        lastv_d   = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_comb begin
    pt_en = '0;
    for (int unsigned i = 0; i < ARRSZ; i++) pt_en[i] = (CW'(i) < ctrl_q);
  end

  assign cmp_out  = cmp_q;
  assign ctrl_out = ctrl_q;
  assign trim_out = trim_q;
  assign lock     = lock_q;

endmodule

// File: tb/tb_ldo_ctrl_v2.sv
// Self-checking bench for ldo_ctrl_v2: a CLKDIV=1 instance for all modes and a
// CLKDIV=4 instance for update-rate and reset checks; expectations flow through a queue.
module tb_ldo_ctrl_v2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] mode_sel;
  logic [9:0] trim;
  logic       cmp_in, std_ctrl_in;
  logic [3:0] std_pt_in_cnt;

  logic       cmp_out, lock, cmp_out4, lock4;
  logic [3:0] ctrl_out, ctrl_out4;
  logic [8:0] pt_en, pt_en4;
  logic [9:0] trim_out, trim_out4;

  typedef struct {
    int ctrl;
    int lock;
    int ctrl4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ldo_ctrl_v2 #(.ARRSZ(9), .TRIMW(10), .MAXSTEP(4), .RUNLEN(3), .LOCKN(4), .CLKDIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .mode_sel(mode_sel), .trim(trim), .cmp_in(cmp_in),
    .std_ctrl_in(std_ctrl_in), .std_pt_in_cnt(std_pt_in_cnt), .cmp_out(cmp_out),
    .ctrl_out(ctrl_out), .pt_en(pt_en), .trim_out(trim_out), .lock(lock)
  );

  ldo_ctrl_v2 #(.ARRSZ(9), .TRIMW(10), .MAXSTEP(4), .RUNLEN(3), .LOCKN(4), .CLKDIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .mode_sel(mode_sel), .trim(trim), .cmp_in(cmp_in),
    .std_ctrl_in(std_ctrl_in), .std_pt_in_cnt(std_pt_in_cnt), .cmp_out(cmp_out4),
    .ctrl_out(ctrl_out4), .pt_en(pt_en4), .trim_out(trim_out4), .lock(lock4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] therm(input int n);
    int v;
    v = (1 << n) - 1;
    return v[8:0];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; mode_sel = 2'b00; trim = '0; cmp_in = 1'b0;
    std_ctrl_in = 1'b0; std_pt_in_cnt = '0;
    #2;
    n_checks++;
    if ({cmp_out, ctrl_out, pt_en, trim_out, lock} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmp=%b ctrl=%0d pt=%b trim=%h lock=%b required all 0",
               cmp_out, ctrl_out, pt_en, trim_out, lock);
    end
    n_checks++;
    if ({cmp_out4, ctrl_out4, pt_en4, trim_out4, lock4} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_div4: got cmp=%b ctrl=%0d pt=%b trim=%h lock=%b required all 0",
               cmp_out4, ctrl_out4, pt_en4, trim_out4, lock4);
    end
    #10 reset_n = 1'b1;
    step_clk();
  endtask

  task automatic test_mode00();
    exp_t e;
    int   cnts[2] = '{3, 15};
    int   exps[2] = '{3, 9};
    mode_sel = 2'b00; trim = 10'h155; cmp_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      std_pt_in_cnt = cnts[i][3:0];
      exp_q.push_back('{ctrl: exps[i], lock: 0, ctrl4: exps[i]});
      step_clk();
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_out !== 4'(e.ctrl) || pt_en !== therm(e.ctrl)) begin
        n_fail++;
        $display("FAIL mode00_load: got ctrl=%0d pt=%b required ctrl=%0d pt=%b",
                 ctrl_out, pt_en, e.ctrl, therm(e.ctrl));
      end
      n_checks++;
      if (ctrl_out4 !== 4'(e.ctrl4)) begin
        n_fail++;
        $display("FAIL mode00_load_div4: got %0d required %0d", ctrl_out4, e.ctrl4);
      end
    end
    n_checks++;
    if (trim_out !== 10'h155) begin
      n_fail++;
      $display("FAIL mode00_trim: got %h required 155", trim_out);
    end
    cmp_in = 1'b1;
    step_clk();
    n_checks++;
    if (cmp_out !== 1'b0) begin
      n_fail++;
      $display("FAIL cmp_sync_edge1: got %b required 0", cmp_out);
    end
    step_clk();
    n_checks++;
    if (cmp_out !== 1'b1) begin
      n_fail++;
      $display("FAIL cmp_sync_edge2: got %b required 1", cmp_out);
    end
  endtask

  task automatic test_fixed();
    exp_t e;
    mode_sel = 2'b00; std_pt_in_cnt = 4'd0; cmp_in = 1'b1;
    repeat (3) step_clk();
    mode_sel = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back('{ctrl: (k - 1 > 9) ? 9 : k - 1, lock: 0, ctrl4: 0});
      step_clk();
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_out !== 4'(e.ctrl) || pt_en !== therm(e.ctrl) || lock !== 1'(e.lock)) begin
        n_fail++;
        $display("FAIL fixed_step_e%0d: got ctrl=%0d pt=%b lock=%b required ctrl=%0d pt=%b lock=%0d",
                 k, ctrl_out, pt_en, lock, e.ctrl, therm(e.ctrl), e.lock);
      end
    end
  endtask

  task automatic test_adaptive();
    exp_t e;
    int   exp_c[16] = '{0, 4, 8, 9, 9, 9, 9, 5, 7, 6, 7, 6, 7, 6, 7, 8};
    int   exp_l[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    logic drv[16]   = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    mode_sel = 2'b00; std_pt_in_cnt = 4'd0; cmp_in = 1'b1;
    repeat (3) step_clk();
    mode_sel = 2'b11;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back('{ctrl: exp_c[k], lock: exp_l[k], ctrl4: 0});
      step_clk();
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_out !== 4'(e.ctrl) || lock !== 1'(e.lock)) begin
        n_fail++;
        $display("FAIL adaptive_e%0d: got ctrl=%0d lock=%b required ctrl=%0d lock=%0d",
                 k + 1, ctrl_out, lock, e.ctrl, e.lock);
      end
      cmp_in = drv[k];
    end
  endtask

  task automatic test_mode01_then_fixed();
    exp_t e;
    int   c01[8] = '{8, 9, 9, 8, 9, 8, 9, 8};
    int   l01[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int   c10[9] = '{8, 7, 8, 9, 9, 9, 9, 8, 7};
    std_ctrl_in = 1'b1; trim = 10'h2A5; mode_sel = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back('{ctrl: c01[k-1], lock: l01[k-1], ctrl4: 0});
      step_clk();
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_out !== 4'(e.ctrl) || lock !== 1'(e.lock)) begin
        n_fail++;
        $display("FAIL mode01_e%0d: got ctrl=%0d lock=%b required ctrl=%0d lock=%0d",
                 k, ctrl_out, lock, e.ctrl, e.lock);
      end
      std_ctrl_in = (k % 2 == 0);
    end
    n_checks++;
    if (trim_out !== 10'h2A5 || cmp_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mode01_trim_cmp: got trim=%h cmp=%b required trim=2a5 cmp=1", trim_out, cmp_out);
    end
    std_ctrl_in = 1'b1; cmp_in = 1'b1; mode_sel = 2'b10;
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back('{ctrl: c10[k-1], lock: 0, ctrl4: 0});
      step_clk();
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_out !== 4'(e.ctrl) || lock !== 1'(e.lock)) begin
        n_fail++;
        $display("FAIL mode10_follow_e%0d: got ctrl=%0d lock=%b required ctrl=%0d lock=%0d",
                 k, ctrl_out, lock, e.ctrl, e.lock);
      end
      if (k == 1) trim = 10'h3FF;
      if (k == 5) cmp_in = 1'b0;
    end
    n_checks++;
    if (trim_out !== 10'h2A5) begin
      n_fail++;
      $display("FAIL mode10_trim_frozen: got %h required 2a5", trim_out);
    end
  endtask

  task automatic test_reset_clkdiv();
    exp_t e;
    mode_sel = 2'b00; std_pt_in_cnt = 4'd5; trim = 10'h155; cmp_in = 1'b1; std_ctrl_in = 1'b1;
    repeat (3) step_clk();
    mode_sel = 2'b10;
    repeat (6) step_clk();
    n_checks++;
    if (ctrl_out !== 4'd9 || ctrl_out4 !== 4'd6) begin
      n_fail++;
      $display("FAIL prereset_counts: got ctrl=%0d ctrl4=%0d required ctrl=9 ctrl4=6",
               ctrl_out, ctrl_out4);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cmp_out, ctrl_out, pt_en, trim_out, lock} !== 25'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got cmp=%b ctrl=%0d pt=%b trim=%h lock=%b required all 0",
               cmp_out, ctrl_out, pt_en, trim_out, lock);
    end
    n_checks++;
    if ({cmp_out4, ctrl_out4, pt_en4, trim_out4, lock4} !== 25'd0) begin
      n_fail++;
      $display("FAIL midrun_reset_div4: got cmp=%b ctrl=%0d pt=%b trim=%h lock=%b required all 0",
               cmp_out4, ctrl_out4, pt_en4, trim_out4, lock4);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      exp_q.push_back('{ctrl: (k - 2 < 0) ? 0 : ((k - 2 > 9) ? 9 : k - 2), lock: 0,
                        ctrl4: (k - 1) / 4});
      step_clk();
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_out4 !== 4'(e.ctrl4) || pt_en4 !== therm(e.ctrl4)) begin
        n_fail++;
        $display("FAIL clkdiv4_e%0d: got ctrl=%0d pt=%b required ctrl=%0d pt=%b",
                 k, ctrl_out4, pt_en4, e.ctrl4, therm(e.ctrl4));
      end
      n_checks++;
      if (ctrl_out !== 4'(e.ctrl)) begin
        n_fail++;
        $display("FAIL after_reset_div1_e%0d: got %0d required %0d", k, ctrl_out, e.ctrl);
      end
    end
    n_checks++;
    if (trim_out4 !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_trim_frozen: got %h required 000", trim_out4);
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_fixed();
    test_adaptive();
    test_mode01_then_fixed();
    test_reset_clkdiv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
